// File: rtl/bcd_to_bin_sequencer_pkg.sv
// Shared definitions for the BCD-to-binary sequencer: the state enum, digit constants,
// and a helper that gives the minimum result width for a digit count.
// No ports. Imported by the sequencer top and the datapath.
package bcd_conv_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest width w with 2**w >= 10**ndigits. This holds 10**ndigits - 1.
  function automatic int min_out_w(input int ndigits);
    longint p;
    int     w;
    p = 1;
    for (int i = 0; i < ndigits; i++) p = p * 10;
    w = 0;
    while ((longint'(1) << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_bin_sequencer_if.sv
// Handshake bundle between a BCD source, the sequencer and a binary consumer.
// Signals: in_valid/in_ready/bcd_in (request side), out_valid/out_ready/out_bin/out_err (result side).
// Modports: master = source/consumer side (the bench), slave = the sequencer.
interface bcd_to_bin_sequencer_if #(
  parameter int NDIGITS = 3,
  parameter int OUT_W   = 10
);

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_bin;
  logic                   out_err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/bcd_to_bin_sequencer_mac10.sv
// Shared datapath of the sequencer. It computes res = acc*10 + digit as (acc<<3) + (acc<<1) + digit.
// Purely combinational, with zero latency. The result wraps modulo 2**OUT_W.
// Ports: acc (OUT_W), digit (4) in; res (OUT_W) out. No backpressure.
module bcd_mac10
  import bcd_conv_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic [OUT_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [OUT_W-1:0]   res
);

  logic [OUT_W-1:0] acc_x8;
  logic [OUT_W-1:0] acc_x2;

  assign acc_x8 = acc << 3;
  assign acc_x2 = acc << 1;
  assign res    = acc_x8 + acc_x2 + OUT_W'(digit);

endmodule

// File: rtl/bcd_to_bin_sequencer.sv
// Converts a packed NDIGITS BCD word to binary. It uses Horner evaluation with the most significant digit first.
// The evaluation uses one shared multiply-by-ten-and-add datapath.
// Latency: out_valid is asserted NDIGITS+1 cycles after the accept. A rejected word takes 1 cycle.
// Backpressure: in_ready is high only in IDLE. out_valid and out_bin hold until out_ready.
// Ports: clk, rst (synchronous, active-high), bus (slave modport: in_valid/in_ready/bcd_in,
//   out_valid/out_ready/out_bin/out_err).
// Optional macro BCD_DIGIT_CHECK_EN: words that contain a digit > 9 go straight to DONE.
//   Such a word gives out_err=1 and out_bin=0. Without the macro, out_err is tied to 0.
module bcd_to_bin_sequencer
  import bcd_conv_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int OUT_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_to_bin_sequencer_if.slave   bus
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int BCD_W = DIGIT_W * NDIGITS;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGIT_W-1:0] cur_digit;
  logic [OUT_W-1:0]   mac_res;

  assign cur_digit = digits_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

  bcd_mac10 #(.OUT_W(OUT_W)) u_mac10 (
    .acc   (acc_q),
    .digit (cur_digit),
    .res   (mac_res)
  );

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  // The check runs on the word as offered. That word is the same one latched on accept.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT)) bad_digit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          digits_d = bus.bcd_in;
          acc_d    = '0;
          idx_d    = IDX_W'(NDIGITS - 1);
          state_d  = ST_CALC;
`ifdef BCD_DIGIT_CHECK_EN
          if (bad_digit) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        acc_d = mac_res;
        if (idx_q == '0) state_d = ST_DONE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
`ifdef BCD_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // acc does not change in DONE, so it can drive out_bin directly. acc stays 0 for a rejected word.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_bin   = acc_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign bus.out_err   = err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_sequencer.sv
// Directed bench for bcd_to_bin_sequencer with the default configuration (3 digits, 10-bit result).
// The bench drives inputs and samples outputs 1 time unit after each rising edge.
module tb_bcd_to_bin_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   lat;
  int   cyc;
  int   t_xfer;
  int   t_acc2;
  logic saw_valid;

  bcd_to_bin_sequencer_if #(.NDIGITS(3), .OUT_W(10)) bus ();

  bcd_to_bin_sequencer #(.NDIGITS(3), .OUT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one word and waits (bounded) for out_valid. The result is not taken.
  // lat counts cycles from the accept cycle to the first out_valid cycle.
  task automatic offer_and_wait(input logic [11:0] bcd, output int latency);
    bus.bcd_in   = bcd;
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.bcd_in   = 12'h555;  // the latched copy must be used from here on
    latency = 1;
    while (!bus.out_valid && latency < 20) begin
      step();
      latency++;
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bin",   32'(bus.out_bin),   32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    rst = 1'b0;
    step();

    // 999, out_ready high
    bus.out_ready = 1'b1;
    offer_and_wait(12'h999, lat);
    chk("999_latency", 32'(lat), 32'd4);
    chk("999_bin",     32'(bus.out_bin), 32'd999);
    chk("999_err",     32'(bus.out_err), 32'd0);
    step();
    chk("999_in_ready_after", 32'(bus.in_ready),  32'd1);
    chk("999_valid_dropped",  32'(bus.out_valid), 32'd0);

    // 000 then 001
    offer_and_wait(12'h000, lat);
    chk("000_bin", 32'(bus.out_bin), 32'd0);
    step();
    offer_and_wait(12'h001, lat);
    chk("001_latency", 32'(lat), 32'd4);
    chk("001_bin", 32'(bus.out_bin), 32'd1);
    step();

    // 123 under backpressure, with 0x456 pulses that must be ignored
    bus.out_ready = 1'b0;
    offer_and_wait(12'h123, lat);
    chk("123_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("123_hold_bin",      32'(bus.out_bin),   32'd123);
      chk("123_hold_valid",    32'(bus.out_valid), 32'd1);
      chk("123_hold_in_ready", 32'(bus.in_ready),  32'd0);
      bus.bcd_in   = 12'h456;
      bus.in_valid = (i % 2 == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    chk("123_after_hold_bin", 32'(bus.out_bin), 32'd123);
    bus.out_ready = 1'b1;
    step();
    chk("123_released_valid",    32'(bus.out_valid), 32'd0);
    chk("123_released_in_ready", 32'(bus.in_ready),  32'd1);

    // Word with a digit above 9
    offer_and_wait(12'hA23, lat);
`ifdef BCD_DIGIT_CHECK_EN
    chk("A23_latency", 32'(lat), 32'd1);
    chk("A23_bin",     32'(bus.out_bin), 32'd0);
    chk("A23_err",     32'(bus.out_err), 32'd1);
    step();
    chk("A23_err_cleared", 32'(bus.out_err), 32'd0);
`else
    chk("A23_latency", 32'(lat), 32'd4);
    chk("A23_bin",     32'(bus.out_bin), 32'd1023);
    chk("A23_err",     32'(bus.out_err), 32'd0);
    step();
`endif

    // Reset during the second CALC cycle
    bus.bcd_in   = 12'h999;
    bus.in_valid = 1'b1;
    step();                 // accepted; now in first CALC cycle
    bus.in_valid = 1'b0;
    step();                 // second CALC cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out_bin",   32'(bus.out_bin),   32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid_pulse", 32'(saw_valid), 32'd0);

    // Back-to-back 050 then 007 with out_ready held high
    bus.bcd_in   = 12'h050;
    bus.in_valid = 1'b1;
    chk("b2b_first_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.bcd_in = 12'h007;   // stays valid, so it is offered continuously
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("b2b_first_latency", 32'(lat), 32'd4);
    chk("b2b_first_bin",     32'(bus.out_bin), 32'd50);
    t_xfer = cyc;
    step();
    chk("b2b_second_in_ready", 32'(bus.in_ready), 32'd1);
    t_acc2 = (bus.in_ready && bus.in_valid) ? cyc : -1;
    chk("b2b_accept_gap", 32'(t_acc2 - t_xfer), 32'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("b2b_second_latency", 32'(lat), 32'd4);
    chk("b2b_second_bin",     32'(bus.out_bin), 32'd7);
    step();
    chk("b2b_idle_after", 32'(bus.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
